// File: rtl/ecc_op_controller.sv
// ---------------------------------------------------------------------------
// ecc_op_controller
//
// APB-programmed sequencer for an external ECC encoder/decoder core.
// Software loads DATA_IN, CODEWORD_WIDTH and NOISE, then writes CTRL to start
// an operation. The controller freezes the operands onto the core_* outputs,
// pulses core_start, waits for core_valid (bounded by TIMEOUT_CYCLES), latches
// the result and pulses operation_done.
//
// Ports
//   clk                 : clock, all logic on the rising edge
//   rst                 : asynchronous reset, active low
//   PSEL/PENABLE/PWRITE : APB control
//   PADDR/PWDATA/PRDATA : APB address, write data, combinational read data
//   core_start          : one-cycle launch pulse to the core
//   core_ctrl           : operation (0 encode, 1 decode, 2 full channel)
//   core_codeword_width : codeword width select
//   core_data_in        : operand data
//   core_noise          : noise pattern
//   core_valid          : core result strobe
//   core_data_out       : core result data
//   core_num_of_errors  : core error count
//   data_out            : latched result data (0 on timeout)
//   num_of_errors       : latched error count (3 on timeout, 0 for encode)
//   operation_done      : one-cycle completion pulse
//   busy                : high whenever an operation is in flight
//
// Register map (PADDR[4:0]):
//   0x00 CTRL[1:0]  0x04 DATA_IN  0x08 CODEWORD_WIDTH[1:0]  0x0C NOISE
//   0x10 STATUS (read-only) {busy, num_of_errors}
// ---------------------------------------------------------------------------
module ecc_op_controller #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       core_start,
  output logic [1:0]                 core_ctrl,
  output logic [1:0]                 core_codeword_width,
  output logic [AMBA_WORD-1:0]       core_data_in,
  output logic [AMBA_WORD-1:0]       core_noise,
  input  logic                       core_valid,
  input  logic [AMBA_WORD-1:0]       core_data_out,
  input  logic [1:0]                 core_num_of_errors,
  output logic [AMBA_WORD-1:0]       data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_DATA   = 5'h04;
  localparam logic [4:0] ADDR_CWW    = 5'h08;
  localparam logic [4:0] ADDR_NOISE  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  state_t                 r_state;
  state_t                 w_state_next;

  logic [1:0]             r_ctrl;
  logic [AMBA_WORD-1:0]   r_data_in;
  logic [1:0]             r_cw_width;
  logic [AMBA_WORD-1:0]   r_noise;

  logic [1:0]             r_core_ctrl;
  logic [1:0]             r_core_cw_width;
  logic [AMBA_WORD-1:0]   r_core_data_in;
  logic [AMBA_WORD-1:0]   r_core_noise;

  logic [AMBA_WORD-1:0]   r_data_out;
  logic [1:0]             r_num_err;
  logic [7:0]             r_cnt;

  logic [4:0]             w_addr;
  logic                   w_busy;
  logic                   w_wr;
  logic                   w_launch;
  logic                   w_timeout;
  logic                   w_unused_addr;

  // Only the low five address bits are decoded; upper bits alias.
  assign w_addr        = PADDR[4:0];
  assign w_unused_addr = ^PADDR;

  // Writes are accepted only while idle; anything arriving mid-operation
  // (including the DONE->IDLE cycle) is silently dropped.
  assign w_wr      = PSEL & PENABLE & PWRITE & ~w_busy;
  assign w_launch  = w_wr & (w_addr == ADDR_CTRL) & (PWDATA[1:0] != 2'b11);
  assign w_timeout = (r_cnt == TIMEOUT_VAL);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_busy         = 1'b1;
    core_start     = 1'b0;
    operation_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_launch) w_state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        core_start   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_valid || w_timeout) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        operation_done = 1'b1;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign busy = w_busy;

  // -------------------------------------------------------------------------
  // Software-visible registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= '0;
      r_data_in  <= '0;
      r_cw_width <= '0;
      r_noise    <= '0;
    end else if (w_wr) begin
      case (w_addr)
        ADDR_CTRL:  r_ctrl     <= PWDATA[1:0];
        ADDR_DATA:  r_data_in  <= PWDATA;
        ADDR_CWW:   r_cw_width <= PWDATA[1:0];
        ADDR_NOISE: r_noise    <= PWDATA;
        default:    ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand snapshot: CTRL comes straight from the bus because it is being
  // written on the very edge that launches the operation.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_ctrl     <= '0;
      r_core_cw_width <= '0;
      r_core_data_in  <= '0;
      r_core_noise    <= '0;
    end else if (w_launch) begin
      r_core_ctrl     <= PWDATA[1:0];
      r_core_cw_width <= r_cw_width;
      r_core_data_in  <= r_data_in;
      r_core_noise    <= r_noise;
    end
  end

  assign core_ctrl           = r_core_ctrl;
  assign core_codeword_width = r_core_cw_width;
  assign core_data_in        = r_core_data_in;
  assign core_noise          = r_core_noise;

  // -------------------------------------------------------------------------
  // Wait counter and result capture. The counter holds the number of WAIT
  // cycles already spent, so the timeout fires on the (TIMEOUT_CYCLES+1)-th
  // WAIT cycle. core_valid takes priority over a coincident timeout.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_data_out <= '0;
      r_num_err  <= '0;
    end else begin
      case (r_state)
        ST_LAUNCH: r_cnt <= '0;
        ST_WAIT: begin
          if (core_valid) begin
            r_data_out <= core_data_out;
            r_num_err  <= (r_core_ctrl == 2'd0) ? 2'b00 : core_num_of_errors;
          end else if (w_timeout) begin
            r_data_out <= '0;
            r_num_err  <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out      = r_data_out;
  assign num_of_errors = r_num_err;

  // -------------------------------------------------------------------------
  // Combinational APB read
  // -------------------------------------------------------------------------
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        ADDR_CTRL:   PRDATA[1:0] = r_ctrl;
        ADDR_DATA:   PRDATA      = r_data_in;
        ADDR_CWW:    PRDATA[1:0] = r_cw_width;
        ADDR_NOISE:  PRDATA      = r_noise;
        ADDR_STATUS: PRDATA[2:0] = {w_busy, r_num_err};
        default:     PRDATA      = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_op_controller.sv
// ---------------------------------------------------------------------------
// tb_ecc_op_controller
//
// Directed bench for ecc_op_controller: encode, decode, timeout, valid vs.
// timeout priority, busy lockout, mid-operation reset and reserved CTRL.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_ecc_op_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          core_start;
  logic [1:0]    core_ctrl;
  logic [1:0]    core_codeword_width;
  logic [DW-1:0] core_data_in;
  logic [DW-1:0] core_noise;
  logic          core_valid = 1'b0;
  logic [DW-1:0] core_data_out = '0;
  logic [1:0]    core_num_of_errors = '0;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic          operation_done;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  ecc_op_controller #(
    .AMBA_ADDR_WIDTH(AW),
    .AMBA_WORD      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .PSEL               (PSEL),
    .PENABLE            (PENABLE),
    .PWRITE             (PWRITE),
    .PADDR              (PADDR),
    .PWDATA             (PWDATA),
    .PRDATA             (PRDATA),
    .core_start         (core_start),
    .core_ctrl          (core_ctrl),
    .core_codeword_width(core_codeword_width),
    .core_data_in       (core_data_in),
    .core_noise         (core_noise),
    .core_valid         (core_valid),
    .core_data_out      (core_data_out),
    .core_num_of_errors (core_num_of_errors),
    .data_out           (data_out),
    .num_of_errors      (num_of_errors),
    .operation_done     (operation_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters: sampled at the edge, so each high cycle counts once.
  always @(posedge clk) begin
    if (core_start)     start_cnt <= start_cnt + 1;
    if (operation_done) done_cnt  <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Returns 1 ns after the committing edge.
  task automatic apb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Combinational read inside the current cycle; consumes no clock edge.
  task automatic apb_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = addr;
    #1;
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int k);
    k = 0;
    while (!operation_done && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  logic [DW-1:0] rd;
  int            k;
  int            s0;
  int            d0;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_done", 32'(operation_done), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ---------------- encode ----------------
    apb_write(32'h0C, 32'h0);
    apb_write(32'h08, 32'h0);
    apb_write(32'h04, 32'h5);
    s0 = start_cnt;
    apb_write(32'h00, 32'h0);
    chk("enc_start", 32'(core_start), 32'd1);
    chk("enc_busy", 32'(busy), 32'd1);
    chk("enc_core_data_in", core_data_in, 32'h5);
    chk("enc_core_ctrl", 32'(core_ctrl), 32'd0);
    @(posedge clk); #1;
    chk("enc_start_gone", 32'(core_start), 32'd0);
    core_valid = 1'b1; core_data_out = 32'h2D; core_num_of_errors = 2'd1;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("enc_done_lat2", 32'(operation_done), 32'd1);
    chk("enc_data_out", data_out, 32'h2D);
    chk("enc_nerr_forced0", 32'(num_of_errors), 32'd0);
    @(posedge clk); #1;
    chk("enc_done_gone", 32'(operation_done), 32'd0);
    chk("enc_idle", 32'(busy), 32'd0);
    chk("enc_one_start", 32'(start_cnt - s0), 32'd1);

    // ---------------- decode, 1 error ----------------
    apb_write(32'h08, 32'h2);
    apb_write(32'h04, 32'h2D);
    apb_write(32'h00, 32'h1);
    chk("dec_core_cww", 32'(core_codeword_width), 32'd2);
    @(posedge clk); #1;
    core_valid = 1'b1; core_data_out = 32'h5; core_num_of_errors = 2'd1;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("dec_done", 32'(operation_done), 32'd1);
    chk("dec_data_out", data_out, 32'h5);
    chk("dec_nerr", 32'(num_of_errors), 32'd1);
    @(posedge clk); #1;
    apb_read(32'h10, rd);
    chk("dec_status", rd, 32'h1);
    apb_read(32'h08, rd);
    chk("dec_cww_rd", rd, 32'h2);

    // ---------------- timeout ----------------
    apb_write(32'h0C, 32'hA5A5);
    apb_write(32'h00, 32'h2);
    chk("to_core_noise", core_noise, 32'hA5A5);
    chk("to_core_ctrl", 32'(core_ctrl), 32'd2);
    wait_done(40, k);
    chk("to_latency", 32'(k), 32'(TO + 2));
    chk("to_data_out", data_out, 32'h0);
    chk("to_nerr", 32'(num_of_errors), 32'd3);

    // ------- core_valid on the timeout cycle wins -------
    apb_write(32'h00, 32'h1);
    repeat (TO + 1) @(posedge clk);
    #1;
    chk("vw_not_done_yet", 32'(operation_done), 32'd0);
    core_valid = 1'b1; core_data_out = 32'hAB; core_num_of_errors = 2'd2;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("vw_done", 32'(operation_done), 32'd1);
    chk("vw_data_out", data_out, 32'hAB);
    chk("vw_nerr", 32'(num_of_errors), 32'd2);

    // ---------------- busy lockout ----------------
    apb_write(32'h04, 32'h33);
    s0 = start_cnt;
    apb_write(32'h00, 32'h0);
    @(posedge clk); #1;
    apb_write(32'h04, 32'hFF);
    apb_read(32'h04, rd);
    chk("bl_data_rd", rd, 32'h33);
    chk("bl_core_data_in", core_data_in, 32'h33);
    apb_read(32'h10, rd);
    chk("bl_status_busy", rd, 32'h6);
    apb_write(32'h00, 32'h1);
    chk("bl_core_ctrl", 32'(core_ctrl), 32'd0);
    core_valid = 1'b1; core_data_out = 32'h77; core_num_of_errors = 2'd1;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("bl_done", 32'(operation_done), 32'd1);
    chk("bl_data_out", data_out, 32'h77);
    chk("bl_one_start", 32'(start_cnt - s0), 32'd1);

    // ---------------- reset mid-WAIT ----------------
    apb_write(32'h0C, 32'h11);
    apb_write(32'h00, 32'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_core_noise", core_noise, 32'h0);
    chk("rw_core_ctrl", 32'(core_ctrl), 32'd0);
    chk("rw_data_out", data_out, 32'h0);
    apb_read(32'h0C, rd);
    chk("rw_noise_rd", rd, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    core_valid = 1'b1; core_data_out = 32'h55; core_num_of_errors = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    core_valid = 1'b0;
    chk("rw_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rw_still_idle", 32'(busy), 32'd0);
    chk("rw_data_kept0", data_out, 32'h0);
    apb_write(32'h04, 32'h9);
    apb_write(32'h00, 32'h1);
    @(posedge clk); #1;
    core_valid = 1'b1; core_data_out = 32'h9; core_num_of_errors = 2'd2;
    @(posedge clk); #1;
    core_valid = 1'b0;
    chk("rw_rerun_done", 32'(operation_done), 32'd1);
    chk("rw_rerun_data", data_out, 32'h9);
    chk("rw_rerun_nerr", 32'(num_of_errors), 32'd2);

    // ---------------- reserved CTRL and unmapped ----------------
    @(posedge clk); #1;
    s0 = start_cnt;
    apb_write(32'h00, 32'h3);
    chk("rs_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rs_no_start", 32'(start_cnt - s0), 32'd0);
    apb_read(32'h00, rd);
    chk("rs_ctrl_rd", rd, 32'h3);
    apb_write(32'h14, 32'hDEAD);
    apb_read(32'h14, rd);
    chk("um_rd", rd, 32'h0);
    apb_read(32'h04, rd);
    chk("um_data_kept", rd, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
